eth_tx_frame_buf: RTL and testbench

- Single-frame transmit buffer directly upstream of the 10BASE-T transmitter.
- Host side writes one frame's bytes (destination MAC through payload) into internal RAM.
- Transmitter side pulls bytes with mem_rd. The block pads the frame to a minimum length, appends the Ethernet FCS, flags the last byte with b_end, and releases the buffer when the transmitter reports t_complete.

---
 rtl/eth_tx_frame_buf.sv | 157 +++++++++++++++
 tb/tb_eth_tx_frame_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_buf.sv
// Single-frame TX buffer: host fills RAM, transmitter pulls bytes with zero pad and CRC32 FCS appended.
// First byte is valid two cycles after wr_last; host is stalled (wr_ready=0) until t_complete releases the buffer.
module eth_tx_frame_buf #(
  parameter int DEPTH      = 1536,
  parameter int AW         = 11,
  parameter int MIN_LEN    = 60,
  parameter int APPEND_FCS = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic       wr_err,
  output logic       frame_valid,
  input  logic       mem_rd,
  output logic [7:0] eth_in,
  output logic       b_end,
  input  logic       t_complete
);

  localparam int IW    = AW + 1;
  localparam int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCS_N = (APPEND_FCS != 0) ? 4 : 0;
  localparam logic [IW-1:0] MIN_I   = IW'(MIN_LEN);
  localparam logic [IW-1:0] FCS_I   = IW'(FCS_N);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic [1:0] {FILL, PREFETCH, SEND, WAIT_DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    ram_q;
  logic [AW-1:0] wr_ptr, len;
  logic [IW-1:0] rd_idx, nxt_idx, pad_len, last_idx;
  logic [31:0]   crc, fcs_word;
  logic          rst_done, discard, wr_err_q;
  logic          wr_fire, overflow, wr_accept, frame_done, advance, ram_rd_en;
  logic          in_data, in_fcs;
  logic [RAW-1:0] ram_rd_addr;
  logic [1:0]    fcs_k;
  logic [7:0]    tx_byte;

  function automatic logic [31:0] crc_fold(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign wr_fire    = wr_valid && wr_ready;
  assign overflow   = wr_fire && !discard && (wr_ptr == DEPTH_A);
  assign wr_accept  = wr_fire && !discard && !overflow;
  assign frame_done = wr_accept && wr_last;

  assign nxt_idx  = rd_idx + IW'(1);
  assign pad_len  = ({1'b0, len} > MIN_I) ? {1'b0, len} : MIN_I;
  assign last_idx = pad_len + FCS_I - IW'(1);
  assign in_data  = rd_idx < {1'b0, len};
  assign in_fcs   = rd_idx >= pad_len;
  assign fcs_k    = 2'(rd_idx - pad_len);
  assign fcs_word = ~crc;
  assign advance  = (state == SEND) && mem_rd && !t_complete && !b_end;

  // The RAM output register only moves on an advance, so it always holds the byte at rd_idx.
  assign ram_rd_en   = (state == PREFETCH) || (advance && (nxt_idx < {1'b0, len}));
  assign ram_rd_addr = (state == PREFETCH) ? '0 : nxt_idx[RAW-1:0];

  always_comb begin
    tx_byte = 8'h00;
    if (in_data) tx_byte = ram_q;
    else if (in_fcs) tx_byte = fcs_word[8*fcs_k +: 8];
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[RAW-1:0]] <= wr_data;
    if (ram_rd_en) ram_q <= mem[ram_rd_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (frame_done) state_nxt = PREFETCH;
      PREFETCH:  state_nxt = SEND;
      SEND: begin
        if (t_complete)          state_nxt = FILL;
        else if (mem_rd && b_end) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (t_complete) state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  always_comb begin
    wr_ready    = 1'b0;
    frame_valid = 1'b0;
    eth_in      = 8'h00;
    b_end       = 1'b0;
    case (state)
      FILL: wr_ready = rst_done;
      SEND: begin
        frame_valid = 1'b1;
        eth_in      = tx_byte;
        b_end       = (rd_idx == last_idx);
      end
      WAIT_DONE: frame_valid = 1'b1;
      default: ;
    endcase
  end

  assign wr_err = wr_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_done <= 1'b0;
      wr_err_q <= 1'b0;
      discard  <= 1'b0;
      wr_ptr   <= '0;
      len      <= '0;
      rd_idx   <= '0;
      crc      <= 32'hFFFFFFFF;
    end else begin
      rst_done <= 1'b1;
      wr_err_q <= overflow;
      if (wr_fire) begin
        // After an overflow everything up to and including the next wr_last is dropped.
        if (discard) begin
          if (wr_last) discard <= 1'b0;
        end else if (overflow) begin
          wr_ptr  <= '0;
          discard <= !wr_last;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          if (wr_last) len <= wr_ptr + AW'(1);
        end
      end
      if (state == PREFETCH) begin
        rd_idx <= '0;
        crc    <= 32'hFFFFFFFF;
      end
      if (advance) begin
        rd_idx <= nxt_idx;
        if (!in_fcs) crc <= crc_fold(crc, tx_byte);
      end
      if (t_complete && (state == SEND || state == WAIT_DONE)) wr_ptr <= '0;
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_buf.sv
module tb_eth_tx_frame_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [2:0] wr_valid, wr_last, wr_ready, wr_err, frame_valid, mem_rd, b_end, t_complete;
  logic [7:0] wr_data [3];
  logic [7:0] eth_in  [3];
  logic [7:0] fb [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       mem_rd;
    logic       t_cmp;
    logic [7:0] eth;
    logic       b_end;
    logic       fv;
    logic       wr_rdy;
  } vec_t;
  vec_t tbl [16];

  // u_a: small RAM, no pad, FCS. u_b: defaults (60-byte pad). u_c: no pad, no FCS.
  eth_tx_frame_buf #(.DEPTH(16), .AW(5), .MIN_LEN(0), .APPEND_FCS(1)) u_a (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid[0]), .wr_data(wr_data[0]), .wr_last(wr_last[0]),
    .wr_ready(wr_ready[0]), .wr_err(wr_err[0]), .frame_valid(frame_valid[0]), .mem_rd(mem_rd[0]),
    .eth_in(eth_in[0]), .b_end(b_end[0]), .t_complete(t_complete[0]));
  eth_tx_frame_buf #(.DEPTH(1536), .AW(11), .MIN_LEN(60), .APPEND_FCS(1)) u_b (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid[1]), .wr_data(wr_data[1]), .wr_last(wr_last[1]),
    .wr_ready(wr_ready[1]), .wr_err(wr_err[1]), .frame_valid(frame_valid[1]), .mem_rd(mem_rd[1]),
    .eth_in(eth_in[1]), .b_end(b_end[1]), .t_complete(t_complete[1]));
  eth_tx_frame_buf #(.DEPTH(16), .AW(5), .MIN_LEN(0), .APPEND_FCS(0)) u_c (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid[2]), .wr_data(wr_data[2]), .wr_last(wr_last[2]),
    .wr_ready(wr_ready[2]), .wr_err(wr_err[2]), .frame_valid(frame_valid[2]), .mem_rd(mem_rd[2]),
    .eth_in(eth_in[2]), .b_end(b_end[2]), .t_complete(t_complete[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0]}});
    return r;
  endfunction

  task automatic pulse(input int sel, input logic rd, input logic tc);
    mem_rd[sel] = rd;
    t_complete[sel] = tc;
    @(negedge clk);
    mem_rd[sel] = 1'b0;
    t_complete[sel] = 1'b0;
  endtask

  // Presents fb[0..n-1]; records wr_err pulses seen after each byte.
  task automatic write_frame(input int sel, input int n, output int err_cnt, output int err_at);
    err_cnt = 0;
    err_at  = -1;
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (wr_ready[sel] !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk($sformatf("wr_ready_wait[%0d]", sel), {31'h0, wr_ready[sel]}, 32'h1);
      wr_valid[sel] = 1'b1;
      wr_data[sel]  = fb[i];
      wr_last[sel]  = (i == n - 1);
      @(negedge clk);
      if (wr_err[sel] === 1'b1) begin
        err_cnt++;
        err_at = i;
      end
    end
    wr_valid[sel] = 1'b0;
    wr_last[sel]  = 1'b0;
  endtask

  // Starts in PREFETCH; drains the whole frame and releases the buffer.
  task automatic tx_check(input int sel, input int n, input int min_len, input bit fcs,
                          input int gap, input string name);
    logic [7:0]  exp_b [0:79];
    logic [31:0] c, cv;
    int padded, total;
    @(negedge clk);
    padded = (n > min_len) ? n : min_len;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < padded; i++) begin
      exp_b[i] = (i < n) ? fb[i] : 8'h00;
      c = crc_ref(c, exp_b[i]);
    end
    total = padded;
    cv = ~c;
    if (fcs) begin
      for (int k = 0; k < 4; k++) exp_b[padded + k] = cv[8*k +: 8];
      total += 4;
    end
    for (int i = 0; i < total; i++) begin
      chk($sformatf("%s eth[%0d]", name, i), {24'h0, eth_in[sel]}, {24'h0, exp_b[i]});
      chk($sformatf("%s b_end[%0d]", name, i), {31'h0, b_end[sel]}, {31'h0, (i == total - 1)});
      pulse(sel, 1'b1, 1'b0);
      repeat (gap - 1) @(negedge clk);
    end
    chk({name, " done_eth"}, {24'h0, eth_in[sel]}, 32'h0);
    chk({name, " done_b_end"}, {31'h0, b_end[sel]}, 32'h0);
    chk({name, " done_fv"}, {31'h0, frame_valid[sel]}, 32'h1);
    pulse(sel, 1'b0, 1'b1);
    chk({name, " rel_fv"}, {31'h0, frame_valid[sel]}, 32'h0);
    chk({name, " rel_wr_ready"}, {31'h0, wr_ready[sel]}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ec, ea;
    tbl[0] = '{1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 1'b0, 8'(8'h31 + i), 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h26, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h39, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'hCB, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

    resetn = 1'b0;
    wr_valid = '0; wr_last = '0; mem_rd = '0; t_complete = '0;
    for (int s = 0; s < 3; s++) wr_data[s] = 8'h00;
    #3;
    chk("rst wr_ready", {29'h0, wr_ready}, 32'h0);
    chk("rst wr_err", {29'h0, wr_err}, 32'h0);
    chk("rst frame_valid", {29'h0, frame_valid}, 32'h0);
    chk("rst b_end", {29'h0, b_end}, 32'h0);
    chk("rst eth_in", {8'h0, eth_in[0], eth_in[1], eth_in[2]}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst held wr_ready", {29'h0, wr_ready}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post-rst wr_ready", {29'h0, wr_ready}, 32'h7);

    // "123456789", mem_rd every 8 cycles, table-driven
    for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
    write_frame(0, 9, ec, ea);
    chk("crc9 wr_err", ec, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pulse(0, tbl[i].mem_rd, tbl[i].t_cmp);
      repeat (7) @(negedge clk);
      chk($sformatf("tbl[%0d] eth", i), {24'h0, eth_in[0]}, {24'h0, tbl[i].eth});
      chk($sformatf("tbl[%0d] b_end", i), {31'h0, b_end[0]}, {31'h0, tbl[i].b_end});
      chk($sformatf("tbl[%0d] fv", i), {31'h0, frame_valid[0]}, {31'h0, tbl[i].fv});
      chk($sformatf("tbl[%0d] wr_ready", i), {31'h0, wr_ready[0]}, {31'h0, tbl[i].wr_rdy});
    end

    // Frame of exactly DEPTH bytes is legal
    for (int i = 0; i < 16; i++) fb[i] = 8'(8'hA0 + 3 * i);
    write_frame(0, 16, ec, ea);
    chk("full wr_err", ec, 0);
    tx_check(0, 16, 0, 1'b1, 2, "full");

    // Overflow: 20 bytes into 16-byte RAM
    for (int i = 0; i < 20; i++) fb[i] = 8'(8'h40 + i);
    write_frame(0, 20, ec, ea);
    chk("ovf err count", ec, 1);
    chk("ovf err byte", ea, 16);
    chk("ovf wr_ready", {31'h0, wr_ready[0]}, 32'h1);
    chk("ovf frame_valid", {31'h0, frame_valid[0]}, 32'h0);
    fb[0] = 8'h01; fb[1] = 8'h23; fb[2] = 8'h45; fb[3] = 8'h67; fb[4] = 8'h89;
    write_frame(0, 5, ec, ea);
    chk("post-ovf wr_err", ec, 0);
    tx_check(0, 5, 0, 1'b1, 3, "post-ovf");

    // Backpressure during SEND, early release by t_complete
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
    write_frame(0, 3, ec, ea);
    @(negedge clk);
    wr_valid[0] = 1'b1; wr_data[0] = 8'h11; wr_last[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp wr_ready[%0d]", i), {31'h0, wr_ready[0]}, 32'h0);
      chk($sformatf("bp eth[%0d]", i), {24'h0, eth_in[0]}, 32'hAA);
      @(negedge clk);
    end
    pulse(0, 1'b0, 1'b1);
    chk("bp rel fv", {31'h0, frame_valid[0]}, 32'h0);
    chk("bp rel wr_ready", {31'h0, wr_ready[0]}, 32'h1);
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    write_frame(0, 4, ec, ea);
    tx_check(0, 4, 0, 1'b1, 2, "bp 2nd");

    // 14-byte frame padded to 60 plus FCS
    for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
    fb[6] = 8'h02; fb[7] = 8'h00; fb[8] = 8'h00; fb[9] = 8'h00; fb[10] = 8'h00; fb[11] = 8'h01;
    fb[12] = 8'h08; fb[13] = 8'h06;
    write_frame(1, 14, ec, ea);
    tx_check(1, 14, 60, 1'b1, 2, "pad");

    // No FCS, one-byte frame
    fb[0] = 8'hA5;
    write_frame(2, 1, ec, ea);
    @(negedge clk);
    chk("nofcs eth", {24'h0, eth_in[2]}, 32'hA5);
    chk("nofcs b_end", {31'h0, b_end[2]}, 32'h1);
    chk("nofcs fv", {31'h0, frame_valid[2]}, 32'h1);
    pulse(2, 1'b1, 1'b0);
    chk("nofcs wait eth", {24'h0, eth_in[2]}, 32'h0);
    chk("nofcs wait b_end", {31'h0, b_end[2]}, 32'h0);
    chk("nofcs wait fv", {31'h0, frame_valid[2]}, 32'h1);
    pulse(2, 1'b1, 1'b1);
    chk("nofcs rel fv", {31'h0, frame_valid[2]}, 32'h0);
    chk("nofcs rel wr_ready", {31'h0, wr_ready[2]}, 32'h1);
    fb[0] = 8'h5A;
    write_frame(2, 1, ec, ea);
    @(negedge clk);
    chk("nofcs2 eth", {24'h0, eth_in[2]}, 32'h5A);
    pulse(2, 1'b1, 1'b1);
    chk("nofcs2 tc-wins fv", {31'h0, frame_valid[2]}, 32'h0);
    chk("nofcs2 tc-wins wr_ready", {31'h0, wr_ready[2]}, 32'h1);

    // Asynchronous reset in the middle of SEND
    for (int i = 0; i < 14; i++) fb[i] = 8'(8'h80 + i);
    write_frame(1, 14, ec, ea);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse(1, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk("mid eth", {24'h0, eth_in[1]}, 32'h83);
    chk("mid fv", {31'h0, frame_valid[1]}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("arst eth", {24'h0, eth_in[1]}, 32'h0);
    chk("arst b_end", {31'h0, b_end[1]}, 32'h0);
    chk("arst fv", {31'h0, frame_valid[1]}, 32'h0);
    chk("arst wr_ready", {31'h0, wr_ready[1]}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst release wr_ready", {31'h0, wr_ready[1]}, 32'h1);
    fb[0] = 8'hDE; fb[1] = 8'hAD;
    write_frame(1, 2, ec, ea);
    tx_check(1, 2, 60, 1'b1, 2, "post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
